// File: rtl/result_acc_pkg.sv
// -----------------------------------------------------------------------------
// result_acc_pkg
//   Shared definitions for result_accumulator:
//     - state_e    : frame FSM states (IDLE, ACCUM, EMIT)
//     - COUNT_W    : width of the sample counter and count_out (holds up to 256)
//     - calc_sum_w : accumulator width that a full frame can never overflow
// -----------------------------------------------------------------------------
package result_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_e;

    localparam int COUNT_W = 9;

    // FRAME_LEN values of at most (2^X_W - 1) each sum to less than
    // 2^(X_W + clog2(FRAME_LEN+1)), so the accumulator needs no wrap handling.
    function automatic int calc_sum_w(input int frame_len, input int x_w);
        return x_w + $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/result_accumulator.sv
// -----------------------------------------------------------------------------
// result_accumulator
//   Collects FRAME_LEN (z, x) result pairs from the arithmetic datapath over a
//   valid/ready handshake, sums x and tracks the maximum z, then emits one
//   summary record per frame over an output valid/ready handshake. While a
//   record is pending the input side is stalled (in_ready=0), so the block
//   decouples the datapath from the result-reporting logic with backpressure.
//
//   Optional build macro: RESULT_ACC_FLUSH_EN
//     When defined, adds input 'flush' which closes a partial frame early.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-low reset
//   in_valid   in   z_in/x_in carry a sample
//   in_ready   out  sample can be accepted this cycle (0 while a record waits)
//   z_in       in   Z_W  unsigned datapath z result
//   x_in       in   X_W  unsigned datapath x result
//   flush      in   (RESULT_ACC_FLUSH_EN only) close the current frame now
//   out_valid  out  summary record valid
//   out_ready  in   downstream accepts the record
//   sum_out    out  SUM_W    sum of x over the frame
//   zmax_out   out  Z_W      maximum z over the frame
//   count_out  out  COUNT_W  number of samples in the record
// -----------------------------------------------------------------------------
module result_accumulator
    import result_acc_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int Z_W       = 8,
    parameter int X_W       = 16,
    parameter int SUM_W     = calc_sum_w(FRAME_LEN, X_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Z_W-1:0]     z_in,
    input  logic [X_W-1:0]     x_in,
`ifdef RESULT_ACC_FLUSH_EN
    input  logic               flush,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   sum_out,
    output logic [Z_W-1:0]     zmax_out,
    output logic [COUNT_W-1:0] count_out
);

    localparam logic [COUNT_W-1:0] FRAME_LEN_C = COUNT_W'(FRAME_LEN);
    localparam bit                 SINGLE_SAMPLE_FRAME = (FRAME_LEN == 1);

    // Unsigned max; on a tie the previously held value is kept.
    function automatic logic [Z_W-1:0] max_keep(input logic [Z_W-1:0] held,
                                                input logic [Z_W-1:0] cand);
        return (cand > held) ? cand : held;
    endfunction

    function automatic logic [SUM_W-1:0] zext_x(input logic [X_W-1:0] x);
        return SUM_W'(x);
    endfunction

    state_e               state_q,     state_d;
    logic [SUM_W-1:0]     sum_q,       sum_d;
    logic [Z_W-1:0]       zmax_q,      zmax_d;
    logic [COUNT_W-1:0]   count_q,     count_d;
    logic [SUM_W-1:0]     sum_out_q,   sum_out_d;
    logic [Z_W-1:0]       zmax_out_q,  zmax_out_d;
    logic [COUNT_W-1:0]   count_out_q, count_out_d;

    logic                 accept;
    logic                 flush_req;
    logic [SUM_W-1:0]     sum_acc;
    logic [Z_W-1:0]       zmax_acc;
    logic [COUNT_W-1:0]   count_acc;

`ifdef RESULT_ACC_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Ready depends only on state (never on in_valid), and is held low while
    // reset is asserted so no sample appears to be taken during reset.
    assign in_ready  = rst && (state_q != EMIT);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == EMIT);
    assign sum_out   = sum_out_q;
    assign zmax_out  = zmax_out_q;
    assign count_out = count_out_q;

    // Running values including the sample offered this cycle.
    assign sum_acc   = sum_q + zext_x(x_in);
    assign zmax_acc  = max_keep(zmax_q, z_in);
    assign count_acc = count_q + COUNT_W'(1);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        zmax_d      = zmax_q;
        count_d     = count_q;
        sum_out_d   = sum_out_q;
        zmax_out_d  = zmax_out_q;
        count_out_d = count_out_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sum_d   = zext_x(x_in);
                    zmax_d  = z_in;
                    count_d = COUNT_W'(1);
                    if (SINGLE_SAMPLE_FRAME || flush_req) begin
                        state_d     = EMIT;
                        sum_out_d   = zext_x(x_in);
                        zmax_out_d  = z_in;
                        count_out_d = COUNT_W'(1);
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (accept) begin
                    sum_d   = sum_acc;
                    zmax_d  = zmax_acc;
                    count_d = count_acc;
                    if ((count_acc == FRAME_LEN_C) || flush_req) begin
                        state_d     = EMIT;
                        sum_out_d   = sum_acc;
                        zmax_out_d  = zmax_acc;
                        count_out_d = count_acc;
                    end
                end else if (flush_req) begin
                    // Early close without a new sample: publish what is held.
                    state_d     = EMIT;
                    sum_out_d   = sum_q;
                    zmax_out_d  = zmax_q;
                    count_out_d = count_q;
                end
            end

            EMIT: begin
                // Record and accumulators are cleared together so IDLE always
                // starts from zero and the outputs read 0 outside EMIT.
                if (out_ready) begin
                    state_d     = IDLE;
                    sum_d       = '0;
                    zmax_d      = '0;
                    count_d     = '0;
                    sum_out_d   = '0;
                    zmax_out_d  = '0;
                    count_out_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            zmax_q      <= '0;
            count_q     <= '0;
            sum_out_q   <= '0;
            zmax_out_q  <= '0;
            count_out_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            zmax_q      <= zmax_d;
            count_q     <= count_d;
            sum_out_q   <= sum_out_d;
            zmax_out_q  <= zmax_out_d;
            count_out_q <= count_out_d;
        end
    end

endmodule

// File: tb/tb_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_result_accumulator
//   Self-checking bench for result_accumulator with FRAME_LEN=4. Directed
//   scenarios plus randomized frames checked against a queue-based reference
//   (plain sum and max over the samples of each frame). The flush scenario is
//   built only when RESULT_ACC_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
module tb_result_accumulator;

    localparam int FL    = 4;
    localparam int Z_W   = 8;
    localparam int X_W   = 16;
    localparam int SUM_W = X_W + $clog2(FL + 1);
    localparam int CW    = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [Z_W-1:0]   z_in = '0;
    logic [X_W-1:0]   x_in = '0;
`ifdef RESULT_ACC_FLUSH_EN
    logic             flush = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] sum_out;
    logic [Z_W-1:0]   zmax_out;
    logic [CW-1:0]    count_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    result_accumulator #(
        .FRAME_LEN (FL),
        .Z_W       (Z_W),
        .X_W       (X_W),
        .SUM_W     (SUM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_in      (z_in),
        .x_in      (x_in),
`ifdef RESULT_ACC_FLUSH_EN
        .flush     (flush),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .zmax_out  (zmax_out),
        .count_out (count_out)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and hold it until the edge that accepts it.
    task automatic send(input logic [X_W-1:0] x, input logic [Z_W-1:0] z);
        int n;
        n = 0;
        in_valid = 1'b1;
        x_in = x;
        z_in = z;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; x_in = 16'd5; z_in = 8'd5;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b need 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b need 0", in_ready); end
        checks++; if (sum_out !== '0) begin errors++; $display("FAIL rst_sum: got %0d need 0", sum_out); end
        checks++; if (zmax_out !== '0) begin errors++; $display("FAIL rst_zmax: got %0d need 0", zmax_out); end
        checks++; if (count_out !== '0) begin errors++; $display("FAIL rst_count: got %0d need 0", count_out); end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b need 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [X_W-1:0] xs [4];
        logic [Z_W-1:0] zs [4];
        xs = '{16'd100, 16'd200, 16'd300, 16'd400};
        zs = '{8'd5, 8'd9, 8'd3, 8'd7};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(xs[i], zs[i]);
            if (i == 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b need 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b need 1", out_valid); end
        checks++; if (sum_out !== SUM_W'(1000)) begin errors++; $display("FAIL basic_sum: got %0d need 1000", sum_out); end
        checks++; if (zmax_out !== 8'd9) begin errors++; $display("FAIL basic_zmax: got %0d need 9", zmax_out); end
        checks++; if (count_out !== 9'd4) begin errors++; $display("FAIL basic_count: got %0d need 4", count_out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_emit: got %0b need 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b need 0", out_valid); end
        checks++; if (sum_out !== '0) begin errors++; $display("FAIL basic_sum_clear: got %0d need 0", sum_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %0b need 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [X_W-1:0] xs [4];
        logic [Z_W-1:0] zs [4];
        xs = '{16'd100, 16'd200, 16'd300, 16'd400};
        zs = '{8'd5, 8'd9, 8'd3, 8'd7};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(xs[i], zs[i]);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || sum_out !== SUM_W'(1000) || zmax_out !== 8'd9 ||
                count_out !== 9'd4 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%0b sum=%0d zmax=%0d count=%0d ready=%0b need 1/1000/9/4/0",
                         c, out_valid, sum_out, zmax_out, count_out, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b need 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b need 1", in_ready); end
    endtask

    task automatic test_max_values();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'hFFFF, 8'hFF);
        checks++; if (sum_out !== SUM_W'(262140)) begin errors++; $display("FAIL max_sum: got %0d need 262140", sum_out); end
        checks++; if (zmax_out !== 8'd255) begin errors++; $display("FAIL max_zmax: got %0d need 255", zmax_out); end
        checks++; if (count_out !== 9'd4) begin errors++; $display("FAIL max_count: got %0d need 4", count_out); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send(16'd50, 8'd20);
        send(16'd60, 8'd30);
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || sum_out !== '0 || zmax_out !== '0 || count_out !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: valid=%0b sum=%0d zmax=%0d count=%0d ready=%0b need all 0",
                     out_valid, sum_out, zmax_out, count_out, in_ready);
        end
        rst = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) send(X_W'(i), Z_W'(i));
        checks++; if (sum_out !== SUM_W'(10)) begin errors++; $display("FAIL midrst_sum: got %0d need 10", sum_out); end
        checks++; if (count_out !== 9'd4) begin errors++; $display("FAIL midrst_count: got %0d need 4", count_out); end
        checks++; if (zmax_out !== 8'd4) begin errors++; $display("FAIL midrst_zmax: got %0d need 4", zmax_out); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_gaps();
        logic [6:0] pat;
        int acc;
        pat = 7'b1101001;   // cycle 0 first: 1,0,0,1,0,1,1
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            x_in = X_W'((i + 1) * 10);
            z_in = Z_W'(i);
            if (pat[i] && in_ready) acc++;
            step();
            if (i == 5) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid: got %0b need 0", out_valid); end
            end
        end
        in_valid = 1'b0;
        checks++; if (acc !== 4) begin errors++; $display("FAIL gaps_accepts: got %0d need 4", acc); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %0b need 1", out_valid); end
        checks++; if (sum_out !== SUM_W'(180)) begin errors++; $display("FAIL gaps_sum: got %0d need 180", sum_out); end
        checks++; if (zmax_out !== 8'd6) begin errors++; $display("FAIL gaps_zmax: got %0d need 6", zmax_out); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int xs[$];
        int zs[$];
        longint exp_sum;
        int exp_max;
        int gap;
        int stall;
        for (int f = 0; f < 25; f++) begin
            xs.delete();
            zs.delete();
            for (int s = 0; s < FL; s++) begin
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    x_in = X_W'($urandom);
                    z_in = Z_W'($urandom);
                    out_ready = 1'($urandom);
                    step();
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_gap_valid f%0d: got %0b need 0", f, out_valid); end
                end
                xs.push_back(int'($urandom_range(0, 65535)));
                zs.push_back((f % 2 == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(250, 255)));
                out_ready = 1'($urandom);
                send(X_W'(xs[s]), Z_W'(zs[s]));
            end
            out_ready = 1'b0;
            exp_sum = 0;
            exp_max = 0;
            foreach (xs[k]) exp_sum += longint'(xs[k]);
            foreach (zs[k]) if (zs[k] > exp_max) exp_max = zs[k];
            checks++;
            if (out_valid !== 1'b1 || sum_out !== SUM_W'(exp_sum) || zmax_out !== Z_W'(exp_max) ||
                count_out !== CW'(xs.size())) begin
                errors++;
                $display("FAIL rnd_record f%0d: valid=%0b sum=%0d zmax=%0d count=%0d need 1/%0d/%0d/%0d",
                         f, out_valid, sum_out, zmax_out, count_out, exp_sum, exp_max, xs.size());
            end
            stall = int'($urandom_range(0, 3));
            for (int c = 0; c < stall; c++) begin
                step();
                checks++;
                if (out_valid !== 1'b1 || sum_out !== SUM_W'(exp_sum) || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_stall f%0d: valid=%0b sum=%0d ready=%0b need 1/%0d/0",
                             f, out_valid, sum_out, in_ready, exp_sum);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drop f%0d: got %0b need 0", f, out_valid); end
        end
    endtask

`ifdef RESULT_ACC_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0;
        send(16'd10, 8'd1);
        send(16'd20, 8'd2);
        flush = 1'b1;
        send(16'd30, 8'd3);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %0b need 1", out_valid); end
        checks++; if (sum_out !== SUM_W'(60)) begin errors++; $display("FAIL flush_sum: got %0d need 60", sum_out); end
        checks++; if (count_out !== 9'd3) begin errors++; $display("FAIL flush_count: got %0d need 3", count_out); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum_out !== SUM_W'(60) || count_out !== 9'd3) begin
            errors++;
            $display("FAIL flush_in_emit: valid=%0b sum=%0d count=%0d need 1/60/3", out_valid, sum_out, count_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ignored: valid=%0b ready=%0b need 0/1", out_valid, in_ready); end
        flush = 1'b1;
        send(16'd77, 8'd8);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum_out !== SUM_W'(77) || count_out !== 9'd1 || zmax_out !== 8'd8) begin
            errors++;
            $display("FAIL flush_idle_accept: valid=%0b sum=%0d count=%0d zmax=%0d need 1/77/1/8",
                     out_valid, sum_out, count_out, zmax_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        send(16'd5, 8'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sum_out !== SUM_W'(5) || count_out !== 9'd1) begin
            errors++;
            $display("FAIL flush_accum_only: valid=%0b sum=%0d count=%0d need 1/5/1", out_valid, sum_out, count_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_max_values();
        test_reset_mid_frame();
        test_gaps();
        test_random();
`ifdef RESULT_ACC_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
